// File: rtl/pu_obuf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pu_obuf_pkg
// Purpose  : Shared state encoding and requester ids for the OBUF read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pu_obuf_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int REQ_LD = 0;
    localparam int REQ_ST = 1;

endpackage : pu_obuf_pkg
`default_nettype wire

// File: rtl/pu_obuf_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pu_obuf_rsp_pipe
// Purpose  : RD_LAT-deep valid+id shift register that follows each accepted
//            read through the fixed OBUF latency.
// Revision : 1.0 - initial release
// ============================================================================
module pu_obuf_rsp_pipe #(
    parameter int RD_LAT = 2,
    parameter int ID_W   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    output logic            tail_v,
    output logic [ID_W-1:0] tail_id,
    output logic            any_v
);

    logic [RD_LAT-1:0] r_vld;
    logic [ID_W-1:0]   r_id [RD_LAT];

    // The pipe advances every cycle; a stalled port only stops new pushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            r_vld[0] <= push;
            r_id[0]  <= push_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    assign tail_v  = r_vld[RD_LAT-1];
    assign tail_id = r_id[RD_LAT-1];
    assign any_v   = |r_vld;

endmodule : pu_obuf_rsp_pipe
`default_nettype wire

// File: rtl/pu_obuf_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pu_obuf_rd_arbiter
// Purpose  : Round-robin burst arbiter for the shared OBUF read port; steers
//            the returned data valid back to the requester that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module pu_obuf_rd_arbiter
    import pu_obuf_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 256,
    parameter int BURST_LEN  = 2,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_v,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          obuf_rd_req,
    output logic [ADDR_WIDTH-1:0]         obuf_rd_addr,
    input  logic                          obuf_rd_ready,
    input  logic [DATA_WIDTH-1:0]         obuf_rd_data,
    output logic [NUM_REQ-1:0]            rsp_v,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int ID_W  = (NUM_REQ   > 1) ? $clog2(NUM_REQ)   : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_rr_nxt;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    w_owner_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_hold;

    logic               w_win_found;
    logic [ID_W-1:0]    w_win_id;
    logic               w_gnt_vld;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_accept;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic               w_tail_v;
    logic [ID_W-1:0]    w_tail_id;
    logic               w_pipe_any;

    // Scan upward from the requester after the last-served one.
    always_comb begin : p_rr_scan
        logic [ID_W-1:0] v_idx;
        v_idx       = '0;
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_win_found && req_v[v_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = v_idx;
            end
        end
    end

    // An open burst keeps the port locked to its owner, requesting or not.
    assign w_gnt_vld = (r_state == BURST) || w_win_found;
    assign w_gnt_id  = (r_state == BURST) ? r_owner : w_win_id;

    always_comb begin
        req_ready = '0;
        if (w_gnt_vld) begin
            req_ready[w_gnt_id] = obuf_rd_ready;
        end
    end

    assign w_accept   = |(req_v & req_ready);
    assign w_sel_addr = req_addr[w_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (BURST_LEN > 1) begin
                        w_state_nxt = BURST;
                        w_owner_nxt = w_gnt_id;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_rr_nxt = w_gnt_id;
                    end
                end
            end
            BURST: begin
                if (w_accept) begin
                    if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = r_owner;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_owner     <= ID_W'(REQ_LD);
            r_beat_cnt  <= '0;
            r_addr_hold <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_addr_hold <= w_sel_addr;
            end
        end
    end

    assign obuf_rd_req  = w_accept;
    assign obuf_rd_addr = w_accept ? w_sel_addr : r_addr_hold;

    pu_obuf_rsp_pipe #(
        .RD_LAT (RD_LAT),
        .ID_W   (ID_W)
    ) u_rsp_pipe (
        .clk     (clk),
        .reset   (reset),
        .push    (w_accept),
        .push_id (w_gnt_id),
        .tail_v  (w_tail_v),
        .tail_id (w_tail_id),
        .any_v   (w_pipe_any)
    );

    always_comb begin
        rsp_v = '0;
        if (w_tail_v) begin
            rsp_v[w_tail_id] = 1'b1;
        end
    end

    assign rsp_data = obuf_rd_data;
    assign busy     = (r_state == BURST) || w_pipe_any;

endmodule : pu_obuf_rd_arbiter
`default_nettype wire

// File: tb/tb_pu_obuf_rd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pu_obuf_rd_arbiter
// Purpose  : Scoreboard bench for BURST_LEN=2 and BURST_LEN=1 arbiters driven
//            by shared stimulus, each with its own OBUF data responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_obuf_rd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 256;
    localparam int RD_LAT  = 2;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_v;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic                      obuf_rd_ready;
    logic [DATA_W-1:0]         obuf_rd_data [2];
    logic [NUM_REQ-1:0]        req_ready    [2];
    logic                      obuf_rd_req  [2];
    logic [ADDR_W-1:0]         obuf_rd_addr [2];
    logic [NUM_REQ-1:0]        rsp_v        [2];
    logic [DATA_W-1:0]         rsp_data     [2];
    logic                      busy         [2];

    always #5 clk = ~clk;

    pu_obuf_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W),
        .BURST_LEN(2), .RD_LAT(RD_LAT)
    ) dut_bl2 (
        .clk(clk), .reset(reset), .req_v(req_v), .req_addr(req_addr),
        .req_ready(req_ready[0]), .obuf_rd_req(obuf_rd_req[0]),
        .obuf_rd_addr(obuf_rd_addr[0]), .obuf_rd_ready(obuf_rd_ready),
        .obuf_rd_data(obuf_rd_data[0]), .rsp_v(rsp_v[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0])
    );

    pu_obuf_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W),
        .BURST_LEN(1), .RD_LAT(RD_LAT)
    ) dut_bl1 (
        .clk(clk), .reset(reset), .req_v(req_v), .req_addr(req_addr),
        .req_ready(req_ready[1]), .obuf_rd_req(obuf_rd_req[1]),
        .obuf_rd_addr(obuf_rd_addr[1]), .obuf_rd_ready(obuf_rd_ready),
        .obuf_rd_data(obuf_rd_data[1]), .rsp_v(rsp_v[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1])
    );

    // Reference model state: last-served requester, open burst owner and
    // number of beats still owed in that burst.
    int                m_last  [2];
    int                m_owner [2];
    int                m_left  [2];
    logic [ADDR_W-1:0] m_addr  [2];
    logic [NUM_REQ-1:0] e_ready [2];
    logic              e_req   [2];
    logic [ADDR_W-1:0] e_addr  [2];
    logic              e_busy  [2];
    rsp_t              sb      [2][$];

    logic [ADDR_W-1:0] hist     [2][RD_LAT];
    logic [ADDR_W-1:0] acc_addr [2];

    int cyc      = 0;
    int n_tests  = 0;
    int n_fail   = 0;
    bit end_chk  = 1'b0;
    bit end_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a, input int c);
        logic [31:0] w;
        w = ({24'd0, a} * 32'h9E37_79B1) ^ (32'(c) * 32'h0055_AA01);
        return {w, ~w, w + 32'd1, w ^ 32'hA5A5_A5A5, w, ~w, w - 32'd1, {24'd0, a}};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            sb[c].delete();
            m_last[c]  = NUM_REQ - 1;
            m_owner[c] = 0;
            m_left[c]  = 0;
            m_addr[c]  = '0;
            e_ready[c] = '0;
            e_req[c]   = 1'b0;
            e_addr[c]  = '0;
            e_busy[c]  = 1'b0;
        end
    endtask

    task automatic model_cycle(input int c);
        int bl;
        int gid;
        bit acc;
        rsp_t e;
        bl  = (c == 0) ? 2 : 1;
        gid = -1;
        acc = 1'b0;
        e_busy[c] = (m_left[c] > 0) || (sb[c].size() > 0);
        if (m_left[c] > 0) begin
            gid = m_owner[c];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (gid < 0 && req_v[(m_last[c] + k) % NUM_REQ]) gid = (m_last[c] + k) % NUM_REQ;
            end
        end
        e_ready[c] = '0;
        if (gid >= 0) begin
            e_ready[c][gid] = obuf_rd_ready;
            acc = obuf_rd_ready && req_v[gid];
        end
        e_req[c] = acc;
        if (acc) begin
            m_addr[c] = req_addr[gid*ADDR_W +: ADDR_W];
            e.id   = gid;
            e.data = mem_f(m_addr[c], c);
            e.due  = cyc + RD_LAT;
            sb[c].push_back(e);
            if (m_left[c] > 0) begin
                m_left[c] = m_left[c] - 1;
                if (m_left[c] == 0) m_last[c] = gid;
            end else if (bl > 1) begin
                m_owner[c] = gid;
                m_left[c]  = bl - 1;
            end else begin
                m_last[c] = gid;
            end
        end
        e_addr[c] = m_addr[c];
    endtask

    task automatic step(input logic [1:0] v, input logic rdy, input logic [15:0] a);
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            for (int s = RD_LAT - 1; s > 0; s--) hist[c][s] = hist[c][s-1];
            hist[c][0] = acc_addr[c];
            obuf_rd_data[c] = mem_f(hist[c][RD_LAT-1], c);
        end
        req_v         = v;
        obuf_rd_ready = rdy;
        req_addr      = a;
        for (int c = 0; c < 2; c++) model_cycle(c);
        #1;
        for (int c = 0; c < 2; c++) acc_addr[c] = obuf_rd_addr[c];
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        req_v         = '0;
        obuf_rd_ready = 1'b1;
        model_reset();
        repeat (ncyc) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic chk(input string name, input int c, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d cyc=%0d: got %0h, expected %0h", name, c, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle handshake checks and scoreboard pops on responses.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            rsp_t e;
            chk("req_ready", c, DATA_W'(req_ready[c]), DATA_W'(e_ready[c]));
            chk("obuf_rd_req", c, DATA_W'(obuf_rd_req[c]), DATA_W'(e_req[c]));
            chk("obuf_rd_addr", c, DATA_W'(obuf_rd_addr[c]), DATA_W'(e_addr[c]));
            chk("busy", c, DATA_W'(busy[c]), DATA_W'(e_busy[c]));
            if (sb[c].size() > 0 && sb[c][0].due == cyc) begin
                e = sb[c].pop_front();
                chk("rsp_v", c, DATA_W'(rsp_v[c]), DATA_W'(2'b01 << e.id));
                chk("rsp_data", c, rsp_data[c], e.data);
            end else begin
                chk("rsp_v_idle", c, DATA_W'(rsp_v[c]), '0);
            end
            if (end_chk && !end_done) begin
                chk("scoreboard_empty", c, DATA_W'(sb[c].size()), '0);
            end
        end
        if (end_chk) end_done <= 1'b1;
    end

    initial begin
        reset         = 1'b1;
        req_v         = '0;
        req_addr      = '0;
        obuf_rd_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            obuf_rd_data[c] = '0;
            acc_addr[c]     = '0;
            for (int s = 0; s < RD_LAT; s++) hist[c][s] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // single requester, addresses 0x10 then 0x11
        step(2'b01, 1'b1, 16'h0010);
        step(2'b01, 1'b1, 16'h0011);
        repeat (4) step(2'b00, 1'b1, 16'($urandom));
        // contention
        repeat (8) step(2'b11, 1'b1, 16'($urandom));
        // burst lock: ST served first so LD wins next, then LD pauses mid-burst
        repeat (2) step(2'b10, 1'b1, 16'($urandom));
        step(2'b00, 1'b1, 16'($urandom));
        step(2'b11, 1'b1, 16'($urandom));
        repeat (2) step(2'b10, 1'b1, 16'($urandom));
        step(2'b11, 1'b1, 16'($urandom));
        repeat (2) step(2'b10, 1'b1, 16'($urandom));
        repeat (2) step(2'b00, 1'b1, 16'($urandom));
        // port stall mid-burst
        step(2'b11, 1'b1, 16'($urandom));
        repeat (3) step(2'b11, 1'b0, 16'($urandom));
        repeat (3) step(2'b11, 1'b1, 16'($urandom));
        repeat (2) step(2'b00, 1'b1, 16'($urandom));
        // randomized traffic
        repeat (300) step(2'($urandom), ($urandom_range(0, 3) != 0), 16'($urandom));
        // reset with reads in flight, then simultaneous request
        repeat (3) step(2'b11, 1'b1, 16'($urandom));
        do_reset(2);
        repeat (4) step(2'b11, 1'b1, 16'($urandom));
        repeat (5) step(2'b00, 1'b1, 16'($urandom));

        end_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pu_obuf_rd_arbiter
`default_nettype wire
